fetch_stage: RTL and testbench
==============================

// Module: fetch_stage
// PURPOSE
//  IF-stage producer for the IF/ID pipeline register. Drives the PC through a
//  req/rsp instruction-memory port and buffers returned words with their PCs
//  in a DEPTH-entry FIFO. Presents the FIFO head as pre_address_fetch and
//  instruction_fetch. Obeys the same redirect (next_select/branch_result/Jalr)
//  and load-stall controls that the IF/ID register consumes.
// PARAMETERS
//  ADDRESS      32     PC / memory address width
//  INSTRUCTION  32     instruction word width
//  RESET_PC     32'h0  first fetch address after reset
//  DEPTH        2      FIFO entries; also max in-flight requests (>=1)
// PORTS
//  clk                input   1            rising-edge clock
//  rst_n              input   1            async active-low reset
//  imem_req_valid     output  1            fetch request valid
//  imem_req_addr      output  ADDRESS      fetch address (current PC)
//  imem_req_ready     input   1            memory accepts request this cycle
//  imem_rsp_valid     input   1            in-order response valid (latency >=1)
//  imem_rsp_data      input   INSTRUCTION  returned instruction word
//  next_select        input   1            JAL redirect
//  branch_result      input   1            taken-branch redirect
//  Jalr               input   1            JALR redirect
//  target_addr        input   ADDRESS      redirect target, valid with any redirect
//  load               input   1            load-use stall: hold current output
//  pre_address_fetch  output  ADDRESS      PC of presented instruction (0 if none)
//  instruction_fetch  output  INSTRUCTION  presented instruction (0 = bubble)
//  fetch_valid        output  1            FIFO head is being presented
// BEHAVIOUR
//  - Reset (async, rst_n=0): pc=RESET_PC; FIFO empty; outstanding=0; drop_cnt=0;
//    imem_req_valid=0; pre_address_fetch=0; instruction_fetch=0; fetch_valid=0.
//  - redirect = next_select|branch_result|Jalr.
//  - Priority: redirect > load > normal.
//  - Issue: imem_req_valid = !redirect && (outstanding - drop_cnt + fifo_count < DEPTH).
//    imem_req_addr = pc. On valid&&ready: pc <= pc+4 (mod 2^ADDRESS),
//    outstanding++.
//  - Response: outstanding-- on every imem_rsp_valid.
//    If drop_cnt>0 or redirect this cycle: word discarded and drop_cnt-- (when >0).
//    Otherwise {pc_of_req, data} is pushed. Request PCs are held in a
//    DEPTH-entry tag queue, popped in order.
//  - Output is combinational from the FIFO head. Empty FIFO -> all outputs 0.
//  - Pop at clock edge when fetch_valid && !load && !redirect.
//    Empty FIFO: bubble, no pop.
//  - Redirect cycle:
//    - pc <= target_addr; FIFO and tag queue flushed.
//    - drop_cnt <= outstanding - imem_rsp_valid.
//    - No request issued.
//    - The outputs still show the old head; IF/ID zeroes them on its side.
//    - The first new request issues the next cycle. Its word is presented no
//      earlier than 2 cycles after the redirect, matching IF/ID's flush + stall.
//  - load: no pop; issue and push continue while space/credit remain.
//    The FIFO never overflows by construction of the credit rule.
//  - Simultaneous push and pop: both occur; count unchanged.
//  - Back-to-back redirects: each retargets pc. drop_cnt is recomputed from
//    outstanding, so stale words are never presented.
//  - target_addr alignment is the producer's duty; no masking here.
//  - Latency: request at PC -> earliest presentation = memory latency + 1 cycle (push edge).
// TESTING
//  1 Reset: rst_n=0 mid-fetch with 2 in flight -> outputs 0 immediately.
//    After release, first imem_req_addr=RESET_PC and drop_cnt=0.
//  2 Streaming: ready=1, 1-cycle rsp, words 0x00000013+i ->
//    pre_address_fetch 0,4,8,... on consecutive cycles with matching words.
//  3 Redirect: branch_result=1, target=0x100, with 2 requests outstanding ->
//    both late responses dropped; next presented PC=0x100; no stale PC appears.
//  4 Load stall: load=1 for 3 cycles while streaming -> outputs held, at most
//    DEPTH requests outstanding; resumes at the next PC with no skip or duplicate.
//  5 Simultaneous: Jalr=1 and load=1 in the same cycle with rsp_valid=1 ->
//    redirect wins; the arriving word is dropped; fetch restarts at target_addr.
//  6 Backpressure/wrap: imem_req_ready=0 for 5 cycles -> req_valid stays high,
//    addr stable. pc=0xFFFFFFFC -> next request addr=0x00000000.

Source files
------------

// File: rtl/fetch_stage_if.sv
// Instruction-memory port of the fetch stage: one request per cycle,
// responses return in order, one per accepted request.
interface fetch_stage_if #(
   parameter int ADDRESS     = 32,
   parameter int INSTRUCTION = 32
);
   logic                   imem_req_valid;
   logic [ADDRESS-1:0]     imem_req_addr;
   logic                   imem_req_ready;
   logic                   imem_rsp_valid;
   logic [INSTRUCTION-1:0] imem_rsp_data;

   modport master (
      output imem_req_valid,
      output imem_req_addr,
      input  imem_req_ready,
      input  imem_rsp_valid,
      input  imem_rsp_data
   );

   modport slave (
      input  imem_req_valid,
      input  imem_req_addr,
      output imem_req_ready,
      output imem_rsp_valid,
      output imem_rsp_data
   );
endinterface

// File: rtl/fetch_stage.sv
// IF-stage producer: issues PCs to instruction memory, queues returned words with their PCs.
// Latency: memory latency + 1 cycle to presentation; credit-limited issue, redirect/load obey IF/ID controls.

// Generic flushable FIFO; head is combinational, caller guarantees no overflow/underflow.
module fifo #(
   parameter int W     = 8,
   parameter int DEPTH = 2
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       flush,
   input  logic                       push,
   input  logic [W-1:0]               push_dat,
   input  logic                       pop,
   output logic [W-1:0]               head_dat,
   output logic [$clog2(DEPTH+1)-1:0] count
);
   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH+1);

   logic [W-1:0]  mem [DEPTH];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(DEPTH-1)) ? '0 : p + 1'b1;
   endfunction

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= ptr_inc(wr_ptr);
         if (pop)  rd_ptr <= ptr_inc(rd_ptr);
         count <= count + CW'(push) - CW'(pop);
      end
   end

   always_ff @(posedge clk) begin
      if (push && !flush) mem[wr_ptr] <= push_dat;
   end

   assign head_dat = mem[rd_ptr];
endmodule

module fetch_stage #(
   parameter int               ADDRESS     = 32,
   parameter int               INSTRUCTION = 32,
   parameter logic [ADDRESS-1:0] RESET_PC  = '0,
   parameter int               DEPTH       = 2
) (
   input  logic                   clk,
   input  logic                   rst_n,
   fetch_stage_if.master          imem,
   input  logic                   next_select,
   input  logic                   branch_result,
   input  logic                   Jalr,
   input  logic [ADDRESS-1:0]     target_addr,
   input  logic                   load,
   output logic [ADDRESS-1:0]     pre_address_fetch,
   output logic [INSTRUCTION-1:0] instruction_fetch,
   output logic                   fetch_valid
);
   localparam int FCW = $clog2(DEPTH+1);
   // Dropped responses stack on top of live ones across back-to-back redirects.
   localparam int CW  = FCW + 4;

   typedef struct packed {
      logic [ADDRESS-1:0]     pc;
      logic [INSTRUCTION-1:0] instr;
   } fetch_entry_t;

   logic [ADDRESS-1:0] pc;
   logic               started;
   logic [CW-1:0]      outstanding;
   logic [CW-1:0]      drop_cnt;
   logic [CW:0]        credit_used;
   logic               redirect;
   logic               issue;
   logic               rsp_keep;
   logic               head_pop;
   logic [ADDRESS-1:0] tag_head;
   logic [FCW-1:0]     tag_count;
   logic [FCW-1:0]     data_count;
   fetch_entry_t       push_entry;
   fetch_entry_t       head_entry;

   assign redirect    = next_select | branch_result | Jalr;
   assign credit_used = {1'b0, outstanding - drop_cnt} + (CW+1)'(data_count);

   // started keeps the request line low for the first cycle out of reset.
   assign imem.imem_req_valid = started && !redirect && (credit_used < (CW+1)'(DEPTH));
   assign imem.imem_req_addr  = pc;
   assign issue               = imem.imem_req_valid && imem.imem_req_ready;

   assign rsp_keep = imem.imem_rsp_valid && (drop_cnt == '0) && !redirect && (tag_count != '0);
   assign head_pop = fetch_valid && !load && !redirect;

   assign push_entry.pc    = tag_head;
   assign push_entry.instr = imem.imem_rsp_data;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         started     <= 1'b0;
         pc          <= RESET_PC;
         outstanding <= '0;
         drop_cnt    <= '0;
      end else begin
         started <= 1'b1;
         if (redirect)   pc <= target_addr;
         else if (issue) pc <= pc + ADDRESS'(4);
         outstanding <= outstanding + CW'(issue) - CW'(imem.imem_rsp_valid);
         if (redirect)
            drop_cnt <= outstanding - CW'(imem.imem_rsp_valid);
         else if (imem.imem_rsp_valid && drop_cnt != '0)
            drop_cnt <= drop_cnt - 1'b1;
      end
   end

   fifo #(.W(ADDRESS), .DEPTH(DEPTH)) u_tag_q (
      .clk      (clk),
      .rst_n    (rst_n),
      .flush    (redirect),
      .push     (issue),
      .push_dat (pc),
      .pop      (rsp_keep),
      .head_dat (tag_head),
      .count    (tag_count)
   );

   fifo #(.W($bits(fetch_entry_t)), .DEPTH(DEPTH)) u_data_q (
      .clk      (clk),
      .rst_n    (rst_n),
      .flush    (redirect),
      .push     (rsp_keep),
      .push_dat (push_entry),
      .pop      (head_pop),
      .head_dat (head_entry),
      .count    (data_count)
   );

   assign fetch_valid       = (data_count != '0);
   assign pre_address_fetch = fetch_valid ? head_entry.pc    : '0;
   assign instruction_fetch = fetch_valid ? head_entry.instr : '0;
endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with an in-order instruction-memory model
// whose words are 0x13 + (addr >> 2).
module tb_fetch_stage;
   logic        clk;
   logic        rst_n;
   logic        next_select;
   logic        branch_result;
   logic        Jalr;
   logic [31:0] target_addr;
   logic        load;
   logic [31:0] pre_address_fetch;
   logic [31:0] instruction_fetch;
   logic        fetch_valid;

   int checks = 0;
   int errors = 0;

   bit          rsp_en = 1'b0;
   logic [31:0] mq[$];
   logic [31:0] seen_pc[$];
   logic [31:0] seen_ins[$];
   int          max_inflight = 0;

   fetch_stage_if #(.ADDRESS(32), .INSTRUCTION(32)) imem ();

   fetch_stage #(.ADDRESS(32), .INSTRUCTION(32), .RESET_PC(32'h0), .DEPTH(2)) dut (
      .clk               (clk),
      .rst_n             (rst_n),
      .imem              (imem),
      .next_select       (next_select),
      .branch_result     (branch_result),
      .Jalr              (Jalr),
      .target_addr       (target_addr),
      .load              (load),
      .pre_address_fetch (pre_address_fetch),
      .instruction_fetch (instruction_fetch),
      .fetch_valid       (fetch_valid)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic logic [31:0] word_of(input logic [31:0] a);
      return 32'h13 + (a >> 2);
   endfunction

   // Memory model: accepts at negedge, answers in the next cycle when rsp_en is set.
   initial begin
      int inflight;
      imem.imem_rsp_valid = 1'b0;
      imem.imem_rsp_data  = '0;
      forever begin
         @(negedge clk);
         if (!rst_n) mq.delete();
         else begin
            inflight = mq.size() + (imem.imem_rsp_valid ? 1 : 0);
            if (inflight > max_inflight) max_inflight = inflight;
            if (imem.imem_req_valid && imem.imem_req_ready) mq.push_back(imem.imem_req_addr);
         end
         @(posedge clk);
         #2;
         if (rst_n && rsp_en && mq.size() > 0) begin
            imem.imem_rsp_valid = 1'b1;
            imem.imem_rsp_data  = word_of(mq.pop_front());
         end else begin
            imem.imem_rsp_valid = 1'b0;
            imem.imem_rsp_data  = '0;
         end
      end
   end

   // Records every entry the consumer actually takes.
   initial begin
      forever begin
         @(negedge clk);
         if (rst_n && fetch_valid && !load && !(next_select || branch_result || Jalr)) begin
            seen_pc.push_back(pre_address_fetch);
            seen_ins.push_back(instruction_fetch);
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Resets the DUT and returns at the negedge of the first cycle with a request.
   task automatic do_reset(input bit ready_v, input bit rsp_v);
      bit got = 1'b0;
      step();
      rst_n = 1'b0;
      next_select = 1'b0; branch_result = 1'b0; Jalr = 1'b0;
      target_addr = '0; load = 1'b0; rsp_en = rsp_v;
      imem.imem_req_ready = ready_v;
      step();
      step();
      rst_n = 1'b1;
      seen_pc.delete();
      seen_ins.delete();
      for (int i = 0; i < 6 && !got; i++) begin
         @(negedge clk);
         if (imem.imem_req_valid) got = 1'b1;
         else step();
      end
      checks++;
      if (!got) begin
         errors++;
         $display("FAIL reset_first_req: no request within 6 cycles of reset release");
      end
   endtask

   task automatic test_reset();
      @(negedge clk);
      checks++;
      if (fetch_valid !== 1'b0 || pre_address_fetch !== 32'h0 || instruction_fetch !== 32'h0 || imem.imem_req_valid !== 1'b0) begin
         errors++;
         $display("FAIL reset_idle: vld=%b pc=%h ins=%h req=%b, want all 0", fetch_valid, pre_address_fetch, instruction_fetch, imem.imem_req_valid);
      end
      do_reset(1'b1, 1'b1);
      step();
      step();
      load = 1'b1;
      @(negedge clk);
      checks++;
      if (fetch_valid !== 1'b1 || pre_address_fetch !== 32'h0 || instruction_fetch !== 32'h13) begin
         errors++;
         $display("FAIL first_present: vld=%b pc=%h ins=%h, want 1 00000000 00000013", fetch_valid, pre_address_fetch, instruction_fetch);
      end
      #1;
      rst_n = 1'b0;
      #1;
      checks++;
      if (fetch_valid !== 1'b0 || pre_address_fetch !== 32'h0 || instruction_fetch !== 32'h0 || imem.imem_req_valid !== 1'b0) begin
         errors++;
         $display("FAIL reset_async: vld=%b pc=%h ins=%h req=%b, want all 0", fetch_valid, pre_address_fetch, instruction_fetch, imem.imem_req_valid);
      end
      do_reset(1'b1, 1'b0);
      checks++;
      if (imem.imem_req_addr !== 32'h0 || dut.drop_cnt !== '0 || fetch_valid !== 1'b0) begin
         errors++;
         $display("FAIL reset_restart: addr=%h drop=%0d vld=%b, want 00000000 0 0", imem.imem_req_addr, dut.drop_cnt, fetch_valid);
      end
   endtask

   task automatic test_streaming();
      do_reset(1'b1, 1'b1);
      repeat (18) step();
      for (int i = 0; i < 6; i++) begin
         checks++;
         if (seen_pc[i] !== 32'(4*i) || seen_ins[i] !== 32'h13 + 32'(i)) begin
            errors++;
            $display("FAIL stream_%0d: pc=%h ins=%h, want pc=%h ins=%h", i, seen_pc[i], seen_ins[i], 32'(4*i), 32'h13 + 32'(i));
         end
      end
   endtask

   task automatic test_redirect();
      bit stale = 1'b0;
      do_reset(1'b1, 1'b0);
      step();
      step();
      branch_result = 1'b1;
      target_addr   = 32'h100;
      @(negedge clk);
      checks++;
      if (imem.imem_req_valid !== 1'b0) begin
         errors++;
         $display("FAIL redir_no_issue: req=%b, want 0", imem.imem_req_valid);
      end
      step();
      branch_result = 1'b0;
      rsp_en = 1'b1;
      seen_pc.delete();
      seen_ins.delete();
      @(negedge clk);
      checks++;
      if (imem.imem_req_valid !== 1'b1 || imem.imem_req_addr !== 32'h100 || dut.drop_cnt !== 2 || fetch_valid !== 1'b0) begin
         errors++;
         $display("FAIL redir_restart: req=%b addr=%h drop=%0d vld=%b, want 1 00000100 2 0", imem.imem_req_valid, imem.imem_req_addr, dut.drop_cnt, fetch_valid);
      end
      repeat (14) step();
      checks++;
      if (seen_pc[0] !== 32'h100 || seen_ins[0] !== 32'h53 || seen_pc[1] !== 32'h104 || seen_ins[1] !== 32'h54) begin
         errors++;
         $display("FAIL redir_target: got %h/%h %h/%h, want 00000100/00000053 00000104/00000054", seen_pc[0], seen_ins[0], seen_pc[1], seen_ins[1]);
      end
      foreach (seen_pc[i]) if (seen_pc[i] < 32'h100) stale = 1'b1;
      checks++;
      if (stale) begin
         errors++;
         $display("FAIL redir_stale: pre-redirect pc presented (first=%h), want none below 00000100", seen_pc[0]);
      end
   endtask

   task automatic test_load();
      do_reset(1'b1, 1'b1);
      max_inflight = 0;
      repeat (5) step();
      load = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         checks++;
         if (fetch_valid !== 1'b1 || pre_address_fetch !== 32'h8 || instruction_fetch !== 32'h15) begin
            errors++;
            $display("FAIL load_hold_%0d: vld=%b pc=%h ins=%h, want 1 00000008 00000015", k, fetch_valid, pre_address_fetch, instruction_fetch);
         end
         step();
      end
      load = 1'b0;
      repeat (16) step();
      for (int i = 0; i < 6; i++) begin
         checks++;
         if (seen_pc[i] !== 32'(4*i) || seen_ins[i] !== 32'h13 + 32'(i)) begin
            errors++;
            $display("FAIL load_seq_%0d: pc=%h ins=%h, want pc=%h ins=%h", i, seen_pc[i], seen_ins[i], 32'(4*i), 32'h13 + 32'(i));
         end
      end
      checks++;
      if (max_inflight > 2) begin
         errors++;
         $display("FAIL load_inflight: max outstanding=%0d, want <=2", max_inflight);
      end
   endtask

   task automatic test_simultaneous();
      do_reset(1'b1, 1'b1);
      step();
      step();
      Jalr        = 1'b1;
      load        = 1'b1;
      target_addr = 32'h200;
      seen_pc.delete();
      seen_ins.delete();
      @(negedge clk);
      checks++;
      if (imem.imem_req_valid !== 1'b0 || imem.imem_rsp_valid !== 1'b1 || instruction_fetch !== 32'h13) begin
         errors++;
         $display("FAIL simul_cycle: req=%b rsp=%b ins=%h, want 0 1 00000013", imem.imem_req_valid, imem.imem_rsp_valid, instruction_fetch);
      end
      step();
      Jalr = 1'b0;
      load = 1'b0;
      @(negedge clk);
      checks++;
      if (imem.imem_req_valid !== 1'b1 || imem.imem_req_addr !== 32'h200 || dut.drop_cnt !== 0 || fetch_valid !== 1'b0) begin
         errors++;
         $display("FAIL simul_restart: req=%b addr=%h drop=%0d vld=%b, want 1 00000200 0 0", imem.imem_req_valid, imem.imem_req_addr, dut.drop_cnt, fetch_valid);
      end
      repeat (10) step();
      checks++;
      if (seen_pc[0] !== 32'h200 || seen_ins[0] !== 32'h93) begin
         errors++;
         $display("FAIL simul_target: got %h/%h, want 00000200/00000093", seen_pc[0], seen_ins[0]);
      end
   endtask

   task automatic test_backpressure();
      do_reset(1'b0, 1'b1);
      for (int k = 0; k < 5; k++) begin
         if (k > 0) begin
            step();
            @(negedge clk);
         end
         checks++;
         if (imem.imem_req_valid !== 1'b1 || imem.imem_req_addr !== 32'h0) begin
            errors++;
            $display("FAIL bp_hold_%0d: req=%b addr=%h, want 1 00000000", k, imem.imem_req_valid, imem.imem_req_addr);
         end
      end
      step();
      imem.imem_req_ready = 1'b1;
      step();
      next_select = 1'b1;
      target_addr = 32'hFFFF_FFFC;
      step();
      next_select = 1'b0;
      seen_pc.delete();
      seen_ins.delete();
      @(negedge clk);
      checks++;
      if (imem.imem_req_valid !== 1'b1 || imem.imem_req_addr !== 32'hFFFF_FFFC) begin
         errors++;
         $display("FAIL wrap_top: req=%b addr=%h, want 1 fffffffc", imem.imem_req_valid, imem.imem_req_addr);
      end
      step();
      @(negedge clk);
      checks++;
      if (imem.imem_req_valid !== 1'b1 || imem.imem_req_addr !== 32'h0) begin
         errors++;
         $display("FAIL wrap_next: req=%b addr=%h, want 1 00000000", imem.imem_req_valid, imem.imem_req_addr);
      end
      repeat (10) step();
      checks++;
      if (seen_pc[0] !== 32'hFFFF_FFFC || seen_ins[0] !== 32'h4000_0012 || seen_pc[1] !== 32'h0 || seen_ins[1] !== 32'h13) begin
         errors++;
         $display("FAIL wrap_words: got %h/%h %h/%h, want fffffffc/40000012 00000000/00000013", seen_pc[0], seen_ins[0], seen_pc[1], seen_ins[1]);
      end
   endtask

   initial begin
      #100000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      rst_n = 1'b1;
      next_select = 1'b0; branch_result = 1'b0; Jalr = 1'b0;
      target_addr = '0; load = 1'b0;
      imem.imem_req_ready = 1'b1;
      #1;
      rst_n = 1'b0;
      test_reset();
      test_streaming();
      test_redirect();
      test_load();
      test_simultaneous();
      test_backpressure();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
